// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding and default fetch-unit constants.
package cpu_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int INST_W_DEF = 32;
  localparam int STEP_DEF   = 4;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_0180;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory req/ack port plus the held-instruction port to decode.
// imem: req/addr are held stable until the cycle ack=1, rdata is valid with ack, one fetch outstanding.
// decode: inst/inst_pc are valid while inst_valid=1; a transfer happens in a cycle with inst_valid && inst_ready.
interface pc_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;
  logic              inst_valid;
  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_ack, imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_ack, imem_rdata, inst_ready
  );
endinterface

// File: rtl/pc_next_sel.sv
// Next-PC selection: sequential, pending, redirect or exception target, aligned to STEP.
module pc_next_sel
  import cpu_pkg::*;
#(
  parameter int                ADDR_W  = ADDR_W_DEF,
  parameter int                STEP    = STEP_DEF,
  parameter logic [ADDR_W-1:0] EXC_VEC = ADDR_W'(EXC_VEC_DEF)
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              pending,
  input  logic [ADDR_W-1:0] pending_target,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              exc_valid,
  output logic              event_valid,
  output logic [ADDR_W-1:0] event_target,
  output logic [ADDR_W-1:0] next_pc
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(STEP - 1);

  // A same-cycle event beats a pending target; an exception beats a redirect.
  always_comb begin
    event_valid  = exc_valid | redirect_valid;
    event_target = (exc_valid ? EXC_VEC : redirect_target) & ALIGN_MASK;
    if (event_valid) begin
      next_pc = event_target;
    end else if (pending) begin
      next_pc = pending_target;
    end else begin
      next_pc = pc + ADDR_W'(STEP);
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch: one outstanding imem fetch, instruction held until decode takes it.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                INST_W    = INST_W_DEF,
  parameter int                STEP      = STEP_DEF,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF),
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(EXC_VEC_DEF)
) (
  input  logic                clk,
  input  logic                resetn,
  pc_fetch_unit_if.master     bus,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_target,
  input  logic                exc_valid,
  output logic [ADDR_W-1:0]   epc,
  output logic [ADDR_W-1:0]   pc,
  output fetch_state_e        state
);

  logic              pending;
  logic [ADDR_W-1:0] pending_target;
  logic              inst_valid;
  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;

  logic              event_valid;
  logic [ADDR_W-1:0] event_target;
  logic [ADDR_W-1:0] next_pc;

  pc_next_sel #(
    .ADDR_W  (ADDR_W),
    .STEP    (STEP),
    .EXC_VEC (EXC_VEC)
  ) u_next_sel (
    .pc              (pc),
    .pending         (pending),
    .pending_target  (pending_target),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .exc_valid       (exc_valid),
    .event_valid     (event_valid),
    .event_target    (event_target),
    .next_pc         (next_pc)
  );

  // Request side decodes only registered state, so nothing loops back from imem_ack.
  assign bus.imem_req   = (state == FETCH);
  assign bus.imem_addr  = pc;
  assign bus.inst_valid = inst_valid;
  assign bus.inst       = inst;
  assign bus.inst_pc    = inst_pc;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= FETCH;
      pc             <= RESET_VEC;
      pending        <= 1'b0;
      pending_target <= '0;
      inst_valid     <= 1'b0;
      inst           <= '0;
      inst_pc        <= '0;
      epc            <= '0;
    end else begin
      if (exc_valid) begin
        epc <= inst_valid ? inst_pc : pc;
      end
      case (state)
        FETCH: begin
          if (bus.imem_ack) begin
            if (event_valid || pending) begin
              // Fetch landed on a stale path: drop the data and restart at the target.
              pc      <= next_pc;
              pending <= 1'b0;
            end else begin
              inst       <= bus.imem_rdata;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              pc         <= next_pc;
              state      <= HOLD;
            end
          end else if (event_valid) begin
            // imem_addr must stay stable until ack, so park the newest target.
            pending        <= 1'b1;
            pending_target <= event_target;
          end
        end
        HOLD: begin
          if (event_valid) begin
            inst_valid <= 1'b0;
            pc         <= event_target;
            state      <= FETCH;
          end else if (bus.inst_ready) begin
            inst_valid <= 1'b0;
            state      <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: cycle vector table, scoreboarded random-latency fetch stream, corner sequences.
module tb_pc_fetch_unit;
  import cpu_pkg::*;

  logic         clk = 1'b0;
  logic         resetn;
  logic         redirect_valid;
  logic [31:0]  redirect_target;
  logic         exc_valid;
  logic [31:0]  epc;
  logic [31:0]  pc;
  fetch_state_e state;

  pc_fetch_unit_if #(.ADDR_W(32), .INST_W(32)) bus ();

  pc_fetch_unit dut (
    .clk             (clk),
    .resetn          (resetn),
    .bus             (bus),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .exc_valid       (exc_valid),
    .epc             (epc),
    .pc              (pc),
    .state           (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        rv;
    logic [31:0] rt;
    logic        ev;
    logic        exp_req;
    logic        exp_iv;
    logic [31:0] exp_inst;
    logic [31:0] exp_inst_pc;
    logic [31:0] exp_pc;
    logic [31:0] exp_epc;
  } vec_t;

  vec_t vecs[16];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic idle_inputs();
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = '0;
    bus.inst_ready  = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    exc_valid       = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  function automatic vec_t mk(input logic ack, input logic [31:0] rdata, input logic ready,
                              input logic rv, input logic [31:0] rt, input logic ev,
                              input logic exp_req, input logic exp_iv, input logic [31:0] exp_inst,
                              input logic [31:0] exp_inst_pc, input logic [31:0] exp_pc,
                              input logic [31:0] exp_epc);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.ready = ready; v.rv = rv; v.rt = rt; v.ev = ev;
    v.exp_req = exp_req; v.exp_iv = exp_iv; v.exp_inst = exp_inst;
    v.exp_inst_pc = exp_inst_pc; v.exp_pc = exp_pc; v.exp_epc = exp_epc;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int wait_cnt;
    int accepted;
    int cyc;
    logic [31:0] model_pc;
    logic [63:0] e;

    //            ack rdata          rdy rv rt            ev  req iv inst           inst_pc        pc             epc
    vecs[0]  = mk(1, 32'h1111_0001, 1, 0, 32'h0,        0,  0, 1, 32'h1111_0001, 32'h0,         32'h4,         32'h0);
    vecs[1]  = mk(0, 32'h0,         1, 0, 32'h0,        0,  1, 0, 32'h1111_0001, 32'h0,         32'h4,         32'h0);
    vecs[2]  = mk(1, 32'h2222_0002, 1, 0, 32'h0,        0,  0, 1, 32'h2222_0002, 32'h4,         32'h8,         32'h0);
    vecs[3]  = mk(0, 32'h0,         1, 0, 32'h0,        0,  1, 0, 32'h2222_0002, 32'h4,         32'h8,         32'h0);
    vecs[4]  = mk(1, 32'h3333_0003, 1, 0, 32'h0,        0,  0, 1, 32'h3333_0003, 32'h8,         32'hC,         32'h0);
    vecs[5]  = mk(0, 32'h0,         0, 0, 32'h0,        0,  0, 1, 32'h3333_0003, 32'h8,         32'hC,         32'h0);
    vecs[6]  = mk(0, 32'h0,         0, 1, 32'h200,      1,  1, 0, 32'h3333_0003, 32'h8,         32'h180,       32'h8);
    vecs[7]  = mk(0, 32'h0,         1, 0, 32'h0,        0,  1, 0, 32'h3333_0003, 32'h8,         32'h180,       32'h8);
    vecs[8]  = mk(1, 32'h4444_0004, 1, 0, 32'h0,        0,  0, 1, 32'h4444_0004, 32'h180,       32'h184,       32'h8);
    vecs[9]  = mk(0, 32'h0,         1, 0, 32'h0,        0,  1, 0, 32'h4444_0004, 32'h180,       32'h184,       32'h8);
    vecs[10] = mk(0, 32'h0,         1, 1, 32'h103,      0,  1, 0, 32'h4444_0004, 32'h180,       32'h184,       32'h8);
    vecs[11] = mk(0, 32'h0,         1, 1, 32'h205,      0,  1, 0, 32'h4444_0004, 32'h180,       32'h184,       32'h8);
    vecs[12] = mk(1, 32'hDEAD_0005, 1, 0, 32'h0,        0,  1, 0, 32'h4444_0004, 32'h180,       32'h204,       32'h8);
    vecs[13] = mk(1, 32'hDEAD_0006, 1, 1, 32'h300,      0,  1, 0, 32'h4444_0004, 32'h180,       32'h300,       32'h8);
    vecs[14] = mk(0, 32'h0,         1, 0, 32'h0,        1,  1, 0, 32'h4444_0004, 32'h180,       32'h300,       32'h300);
    vecs[15] = mk(1, 32'hDEAD_0007, 1, 0, 32'h0,        0,  1, 0, 32'h4444_0004, 32'h180,       32'h180,       32'h300);

    do_reset();
    check1 ("rst_req",        bus.imem_req,   1'b1);
    check32("rst_addr",       bus.imem_addr,  32'h0);
    check32("rst_pc",         pc,             32'h0);
    check1 ("rst_inst_valid", bus.inst_valid, 1'b0);
    check32("rst_inst",       bus.inst,       32'h0);
    check32("rst_inst_pc",    bus.inst_pc,    32'h0);
    check32("rst_epc",        epc,            32'h0);

    for (int i = 0; i < 16; i++) begin
      bus.imem_ack    = vecs[i].ack;
      bus.imem_rdata  = vecs[i].rdata;
      bus.inst_ready  = vecs[i].ready;
      redirect_valid  = vecs[i].rv;
      redirect_target = vecs[i].rt;
      exc_valid       = vecs[i].ev;
      step();
      check1 ($sformatf("vec%0d_req", i),     bus.imem_req,   vecs[i].exp_req);
      check1 ($sformatf("vec%0d_iv", i),      bus.inst_valid, vecs[i].exp_iv);
      check32($sformatf("vec%0d_inst", i),    bus.inst,       vecs[i].exp_inst);
      check32($sformatf("vec%0d_inst_pc", i), bus.inst_pc,    vecs[i].exp_inst_pc);
      check32($sformatf("vec%0d_pc", i),      pc,             vecs[i].exp_pc);
      check32($sformatf("vec%0d_addr", i),    bus.imem_addr,  vecs[i].exp_pc);
      check32($sformatf("vec%0d_epc", i),     epc,            vecs[i].exp_epc);
    end
    idle_inputs();

    // Scoreboard: random memory latency and decode back-pressure over a sequential stream.
    do_reset();
    wait_cnt = $urandom_range(0, 3);
    model_pc = 32'h0;
    accepted = 0;
    cyc      = 0;
    while (accepted < 20 && cyc < 2000) begin
      idle_inputs();
      if (bus.imem_req) begin
        if (wait_cnt == 0) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = $urandom;
          check32("sb_addr", bus.imem_addr, model_pc);
          exp_q.push_back({model_pc, bus.imem_rdata});
          model_pc = model_pc + 32'd4;
          wait_cnt = $urandom_range(0, 3);
        end else begin
          wait_cnt--;
        end
      end
      bus.inst_ready = 1'($urandom_range(0, 1));
      if (bus.inst_valid && bus.inst_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got unexpected inst %h expected none", bus.inst);
        end else begin
          e = exp_q.pop_front();
          check32("sb_inst_pc", bus.inst_pc, e[63:32]);
          check32("sb_inst",    bus.inst,    e[31:0]);
          accepted++;
        end
      end
      step();
      cyc++;
    end
    if (accepted < 20) check32("sb_timeout", 32'(accepted), 32'd20);
    check32("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    idle_inputs();

    // Wrap at the top of the address space.
    do_reset();
    bus.imem_ack = 1'b1; redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step();
    check32("wrap_pc_set", pc, 32'hFFFF_FFFC);
    check1 ("wrap_discard_iv", bus.inst_valid, 1'b0);
    idle_inputs();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hCAFE_0001;
    step();
    check32("wrap_inst_pc", bus.inst_pc, 32'hFFFF_FFFC);
    check32("wrap_pc", pc, 32'h0);
    check1 ("wrap_iv", bus.inst_valid, 1'b1);

    // Decode back-pressure for 5 cycles.
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      step();
      check1 ("bp_iv",      bus.inst_valid, 1'b1);
      check32("bp_inst",    bus.inst,       32'hCAFE_0001);
      check32("bp_inst_pc", bus.inst_pc,    32'hFFFF_FFFC);
      check1 ("bp_req",     bus.imem_req,   1'b0);
    end
    bus.inst_ready = 1'b1;
    step();
    check1 ("bp_release_req",  bus.imem_req,  1'b1);
    check32("bp_release_addr", bus.imem_addr, 32'h0);
    check1 ("bp_release_iv",   bus.inst_valid, 1'b0);

    // Reset during an outstanding fetch with a pending redirect.
    idle_inputs();
    bus.imem_ack = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40;
    step();
    check32("rp_pc_40", pc, 32'h40);
    idle_inputs();
    redirect_valid = 1'b1; redirect_target = 32'h100;
    step();
    check32("rp_pc_stable", pc, 32'h40);
    idle_inputs();
    resetn = 1'b0;
    step();
    check32("rp_rst_pc",  pc,             32'h0);
    check1 ("rp_rst_req", bus.imem_req,   1'b1);
    check1 ("rp_rst_iv",  bus.inst_valid, 1'b0);
    resetn = 1'b1;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hBEEF_0001;
    step();
    check1 ("rp_no_pending_iv", bus.inst_valid, 1'b1);
    check32("rp_inst_pc",       bus.inst_pc,    32'h0);
    check32("rp_pc",            pc,             32'h4);
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
